// File: rtl/hist_pkg.sv
// Shared types and arithmetic helpers for the streaming histogram engine.
package hist_pkg;

    // Engine control states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Operand width of the saturating adder; any counter width up to this fits.
    localparam int unsigned ADD_W = 32;

    // Saturating add clamped to cnt_w bits. Bit ADD_W of the result flags that
    // the true sum did not fit and was clamped to all-ones.
    function automatic logic [ADD_W:0] sat_add(
        input logic [ADD_W-1:0] base,
        input logic [ADD_W-1:0] inc,
        input int unsigned      cnt_w
    );
        logic [ADD_W:0] sum_v;
        logic [ADD_W:0] max_v;
        sum_v = {1'b0, base} + {1'b0, inc};
        max_v = ((ADD_W+1)'(1) << cnt_w) - (ADD_W+1)'(1);
        if (sum_v > max_v) begin
            sat_add = {1'b1, max_v[ADD_W-1:0]};
        end else begin
            sat_add = {1'b0, sum_v[ADD_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/hist_stream_engine_if.sv
// Pixel stream and bin readout bundle of the histogram engine.
interface hist_stream_engine_if #(
    parameter int LANES = 8,
    parameter int PIX_W = 8,
    parameter int BIN_W = 6,
    parameter int CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*PIX_W-1:0] in_data;
    logic [LANES-1:0]       in_mask;
    logic                   in_last;
    logic                   rd_en;
    logic [BIN_W-1:0]       rd_bin;
    logic                   rd_valid;
    logic [CNT_W-1:0]       rd_data;

    modport master (
        output in_valid, in_data, in_mask, in_last, rd_en, rd_bin,
        input  in_ready, rd_valid, rd_data
    );

    modport slave (
        input  in_valid, in_data, in_mask, in_last, rd_en, rd_bin,
        output in_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/hist_merge.sv
// Per-beat increment generator: counts how many enabled lanes hit each bin,
// so duplicate bins inside one beat collapse into a single increment.
module hist_merge #(
    parameter int LANES = 8,
    parameter int BIN_W = 6,
    parameter int BINS  = 64,
    parameter int INC_W = 4
) (
    input  logic [LANES*BIN_W-1:0] lane_bin,
    input  logic [LANES-1:0]       lane_en,
    output logic [INC_W-1:0]       bin_inc [BINS]
);

    // Popcount of matching enabled lanes for every bin
    always_comb begin
        for (int b = 0; b < BINS; b++) begin
            bin_inc[b] = '0;
            for (int l = 0; l < LANES; l++) begin
                if (lane_en[l] && (lane_bin[l*BIN_W +: BIN_W] == BIN_W'(b))) begin
                    bin_inc[b] = bin_inc[b] + INC_W'(1);
                end else begin
                    bin_inc[b] = bin_inc[b];
                end
            end
        end
    end

endmodule

// File: rtl/hist_stream_engine.sv
// Streaming histogram accumulator: sweeps the bins to zero on clear, then
// accumulates LANES pixels per beat through a two-stage pipeline with
// saturating counters, and serves a registered single-bin read port.
module hist_stream_engine
    import hist_pkg::*;
#(
    parameter  int LANES = 8,
    parameter  int PIX_W = 8,
    parameter  int BINS  = 64,
    parameter  int CNT_W = 16,
    localparam int BIN_W = $clog2(BINS),
    localparam int SHIFT = PIX_W - BIN_W,
    localparam int INC_W = $clog2(LANES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    hist_stream_engine_if.slave   bus,
    output logic                  busy,
    output logic                  done,
    output logic                  sat_flag
);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [BIN_W-1:0]       clr_idx_r;
    logic                   drain_cnt_r;
    logic                   busy_r, busy_nxt_s;
    logic                   done_r, done_nxt_s;
    logic                   in_ready_r, in_ready_nxt_s;
    logic                   sat_flag_r;
    logic                   accept_s;
    logic                   clear_start_s;
    logic                   rd_ok_s;

    logic [LANES*BIN_W-1:0] pix_bin_s;
    logic                   s1_valid_r;
    logic [LANES*BIN_W-1:0] s1_bin_r;
    logic [LANES-1:0]       s1_mask_r;

    logic [INC_W-1:0]       inc_s     [BINS];
    logic [ADD_W:0]         sum_s     [BINS];
    logic [CNT_W-1:0]       cnt_nxt_s [BINS];
    logic [CNT_W-1:0]       cnt_r     [BINS];
    logic                   sat_any_s;

    logic                   rd_valid_r;
    logic [CNT_W-1:0]       rd_data_r;

    assign accept_s      = bus.in_valid & in_ready_r;
    assign clear_start_s = clear & ((state_r == ST_IDLE) | (state_r == ST_DONE));
    assign rd_ok_s       = bus.rd_en & ((state_r == ST_IDLE) | (state_r == ST_DONE));

    assign bus.in_ready  = in_ready_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data   = rd_data_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign sat_flag      = sat_flag_r;

    // Next-state and registered-output decode of the control FSM
    always_comb begin
        state_nxt_s    = state_r;
        busy_nxt_s     = 1'b0;
        done_nxt_s     = 1'b0;
        in_ready_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE:  state_nxt_s = clear_start_s ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_nxt_s = (clr_idx_r == BIN_W'(BINS - 1)) ? ST_ACCUM : ST_CLEAR;
            ST_ACCUM: state_nxt_s = (accept_s && bus.in_last) ? ST_DRAIN : ST_ACCUM;
            ST_DRAIN: state_nxt_s = drain_cnt_r ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nxt_s = clear_start_s ? ST_CLEAR : ST_DONE;
            default:  state_nxt_s = ST_IDLE;
        endcase
        case (state_nxt_s)
            ST_CLEAR: busy_nxt_s = 1'b1;
            ST_ACCUM: begin
                busy_nxt_s     = 1'b1;
                in_ready_nxt_s = 1'b1;
            end
            ST_DRAIN: busy_nxt_s = 1'b1;
            ST_DONE:  done_nxt_s = 1'b1;
            default:  busy_nxt_s = 1'b0;
        endcase
    end

    // State register, sweep index, drain timer and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            clr_idx_r   <= '0;
            drain_cnt_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            clr_idx_r   <= (state_r == ST_CLEAR) ? clr_idx_r + BIN_W'(1) : '0;
            drain_cnt_r <= (state_r == ST_DRAIN) ? ~drain_cnt_r : 1'b0;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
        end
    end

    // Bin index of every lane is the pixel's top BIN_W bits
    always_comb begin
        pix_bin_s = '0;
        for (int l = 0; l < LANES; l++) begin
            pix_bin_s[l*BIN_W +: BIN_W] = bus.in_data[l*PIX_W + SHIFT +: BIN_W];
        end
    end

    // S1: capture bin indices and lane mask of the accepted beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_r <= 1'b0;
            s1_bin_r   <= '0;
            s1_mask_r  <= '0;
        end else begin
            s1_valid_r <= accept_s;
            s1_bin_r   <= pix_bin_s;
            s1_mask_r  <= accept_s ? bus.in_mask : '0;
        end
    end

    hist_merge #(
        .LANES (LANES),
        .BIN_W (BIN_W),
        .BINS  (BINS),
        .INC_W (INC_W)
    ) u_merge (
        .lane_bin (s1_bin_r),
        .lane_en  (s1_mask_r & {LANES{s1_valid_r}}),
        .bin_inc  (inc_s)
    );

    // S2: saturating sum of every counter with its merged increment
    always_comb begin
        sat_any_s = 1'b0;
        for (int b = 0; b < BINS; b++) begin
            sum_s[b]     = sat_add(ADD_W'(cnt_r[b]), ADD_W'(inc_s[b]), CNT_W);
            cnt_nxt_s[b] = sum_s[b][CNT_W-1:0];
            sat_any_s    = sat_any_s | (sum_s[b][ADD_W] & s1_valid_r);
        end
    end

    // Counter array: one bin zeroed per cycle during CLEAR, else S2 update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < BINS; b++) begin
                cnt_r[b] <= '0;
            end
        end else if (state_r == ST_CLEAR) begin
            cnt_r[clr_idx_r] <= '0;
        end else if (s1_valid_r) begin
            for (int b = 0; b < BINS; b++) begin
                cnt_r[b] <= cnt_nxt_s[b];
            end
        end
    end

    // Sticky saturation flag, dropped when a new frame starts
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_flag_r <= 1'b0;
        end else if (clear_start_s) begin
            sat_flag_r <= 1'b0;
        end else if (sat_any_s) begin
            sat_flag_r <= 1'b1;
        end
    end

    // Read port: served only while idle or done; data holds when refused
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
        end else if (rd_ok_s) begin
            rd_valid_r <= 1'b1;
            rd_data_r  <= cnt_r[bus.rd_bin];
        end else begin
            rd_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hist_stream_engine.sv
// Scoreboard bench for hist_stream_engine: a reference histogram is updated
// on each accepted beat, expected read data is queued when a read is issued
// and compared when rd_valid returns. A second instance with 4-bit counters
// covers saturation.
`timescale 1ns/1ps
module tb_hist_stream_engine;

    localparam int LANES  = 8;
    localparam int PIX_W  = 8;
    localparam int BINS   = 64;
    localparam int BIN_W  = 6;
    localparam int CNT_W  = 16;
    localparam int SCNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic s_clear;
    logic busy, done, sat_flag;
    logic s_busy, s_done, s_sat;

    always #5 clk = ~clk;

    hist_stream_engine_if #(.LANES(LANES), .PIX_W(PIX_W), .BIN_W(BIN_W), .CNT_W(CNT_W))  bus_m ();
    hist_stream_engine_if #(.LANES(LANES), .PIX_W(PIX_W), .BIN_W(BIN_W), .CNT_W(SCNT_W)) bus_s ();

    hist_stream_engine #(.LANES(LANES), .PIX_W(PIX_W), .BINS(BINS), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .clear    (clear),
        .bus      (bus_m),
        .busy     (busy),
        .done     (done),
        .sat_flag (sat_flag)
    );

    hist_stream_engine #(.LANES(LANES), .PIX_W(PIX_W), .BINS(BINS), .CNT_W(SCNT_W)) dut_sat (
        .clk      (clk),
        .reset    (rst_n),
        .clear    (s_clear),
        .bus      (bus_s),
        .busy     (s_busy),
        .done     (s_done),
        .sat_flag (s_sat)
    );

    int          n_vec  = 0;
    int          n_miss = 0;
    int unsigned exp_hist [BINS];
    logic [CNT_W-1:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pop the scoreboard whenever the read port answers
    always @(negedge clk) begin
        logic [CNT_W-1:0] e;
        if (rst_n === 1'b1 && bus_m.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("rd_data", 32'(bus_m.rd_data), 32'(e));
            end
        end
    end

    task automatic model_reset();
        for (int b = 0; b < BINS; b++) exp_hist[b] = 0;
    endtask

    task automatic model_beat(input logic [63:0] data, input logic [7:0] mask);
        int unsigned b;
        for (int l = 0; l < LANES; l++) begin
            if (mask[l]) begin
                b = int'(data[l*8 +: 8]) / 4;
                if (exp_hist[b] < 65535) exp_hist[b] = exp_hist[b] + 1;
            end
        end
    endtask

    task automatic do_clear(output int busy_cyc);
        bit ok;
        busy_cyc = 0;
        ok = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_m.in_ready) begin ok = 1'b1; break; end
            if (busy) busy_cyc++;
        end
        if (!ok) check_val("clear_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [63:0] data, input logic [7:0] mask, input logic last);
        bit ok;
        ok = 1'b0;
        bus_m.in_valid = 1'b1;
        bus_m.in_data  = data;
        bus_m.in_mask  = mask;
        bus_m.in_last  = last;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus_m.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check_val("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        if (ok) model_beat(data, mask);
        #1;
        bus_m.in_valid = 1'b0;
        bus_m.in_last  = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output logic rdy_first);
        cyc = 0;
        rdy_first = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (k == 0) rdy_first = bus_m.in_ready;
            if (done) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic read_bin(input int b);
        bus_m.rd_en  = 1'b1;
        bus_m.rd_bin = BIN_W'(b);
        exp_q.push_back(CNT_W'(exp_hist[b]));
        @(posedge clk); #1;
        bus_m.rd_en  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        logic        r;
        logic [63:0] d;
        bit          ok;

        rst_n = 1'b0; clear = 1'b0; s_clear = 1'b0;
        bus_m.in_valid = 1'b0; bus_m.in_data = '0; bus_m.in_mask = '0; bus_m.in_last = 1'b0;
        bus_m.rd_en = 1'b0; bus_m.rd_bin = '0;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_mask = '0; bus_s.in_last = 1'b0;
        bus_s.rd_en = 1'b0; bus_s.rd_bin = '0;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy",     32'(busy), 32'd0);
        check_val("rst_done",     32'(done), 32'd0);
        check_val("rst_in_ready", 32'(bus_m.in_ready), 32'd0);
        check_val("rst_sat",      32'(sat_flag), 32'd0);
        check_val("rst_rd_valid", 32'(bus_m.rd_valid), 32'd0);
        check_val("rst_rd_data",  32'(bus_m.rd_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clear sweep length, then an empty masked frame
        do_clear(c);
        check_val("clear_cycles", 32'(c), 32'd64);
        check_val("accum_busy", 32'(busy), 32'd1);
        send_beat(64'd0, 8'h00, 1'b1);
        wait_done(c, r);
        check_val("done_lat_nomask", 32'(c), 32'd3);
        read_bin(5);
        read_bin(63);

        // Pixels 0,4,..,28 spread over bins 0..7
        do_clear(c);
        for (int i = 0; i < LANES; i++) d[i*8 +: 8] = 8'(4 * i);
        send_beat(d, 8'hFF, 1'b1);
        wait_done(c, r);
        check_val("done_lat", 32'(c), 32'd3);
        check_val("ready_drop_b", 32'(r), 32'd0);
        for (int b = 0; b <= 8; b++) read_bin(b);

        // All lanes 0xFF, half masked off
        do_clear(c);
        send_beat({8{8'hFF}}, 8'h0F, 1'b1);
        wait_done(c, r);
        read_bin(63);
        read_bin(0);
        read_bin(10);

        // Five beats of 0x40 with idle gaps, plus a refused read mid-frame
        do_clear(c);
        for (int i = 0; i < 5; i++) begin
            send_beat({8{8'h40}}, 8'hFF, (i == 4) ? 1'b1 : 1'b0);
            if (i == 2) begin
                bus_m.rd_en = 1'b1; bus_m.rd_bin = BIN_W'(16);
                @(posedge clk); #1;
                bus_m.rd_en = 1'b0;
                @(negedge clk);
                check_val("rd_refused", 32'(bus_m.rd_valid), 32'd0);
                @(posedge clk); #1;
            end else if (i < 4) begin
                @(posedge clk); #1;
            end
        end
        wait_done(c, r);
        check_val("ready_drop", 32'(r), 32'd0);
        check_val("done_flag", 32'(done), 32'd1);
        read_bin(16);
        read_bin(17);

        // Clear and read together in DONE: read sees the pre-clear count
        bus_m.rd_en = 1'b1; bus_m.rd_bin = BIN_W'(16); clear = 1'b1;
        exp_q.push_back(CNT_W'(exp_hist[16]));
        @(posedge clk); #1;
        bus_m.rd_en = 1'b0; clear = 1'b0;
        model_reset();
        @(negedge clk);
        check_val("clear_rd_busy", 32'(busy), 32'd1);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_m.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check_val("clear2_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        send_beat({8{8'h40}}, 8'hFF, 1'b0);

        // Reset mid-frame: outputs drop immediately
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_in_ready", 32'(bus_m.in_ready), 32'd0);
        check_val("mid_rst_busy",     32'(busy), 32'd0);
        check_val("mid_rst_done",     32'(done), 32'd0);
        check_val("mid_rst_rd_data",  32'(bus_m.rd_data), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        read_bin(16);

        // Saturation on the 4-bit counter instance
        s_clear = 1'b1;
        @(posedge clk); #1;
        s_clear = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus_s.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check_val("sat_clear_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus_s.in_valid = 1'b1; bus_s.in_data = '0; bus_s.in_mask = 8'hFF; bus_s.in_last = 1'b0;
        @(posedge clk); #1;
        bus_s.in_last = 1'b1;
        @(posedge clk); #1;
        bus_s.in_valid = 1'b0; bus_s.in_last = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_done) begin ok = 1'b1; break; end
        end
        check_val("sat_done", 32'(ok), 32'd1);
        check_val("sat_flag_set", 32'(s_sat), 32'd1);
        @(posedge clk); #1;
        bus_s.rd_en = 1'b1; bus_s.rd_bin = '0;
        @(posedge clk); #1;
        bus_s.rd_en = 1'b0;
        @(negedge clk);
        check_val("sat_rd_valid", 32'(bus_s.rd_valid), 32'd1);
        check_val("sat_rd_data",  32'(bus_s.rd_data), 32'd15);
        @(posedge clk); #1;
        s_clear = 1'b1;
        @(posedge clk); #1;
        s_clear = 1'b0;
        @(negedge clk);
        check_val("sat_flag_cleared", 32'(s_sat), 32'd0);
        check_val("sat_busy", 32'(s_busy), 32'd1);

        @(posedge clk);
        @(negedge clk);
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hist_stream_engine.md
Name: hist_stream_engine

Overview:
- Parametrised streaming histogram accumulator; generalises the fixed 64-bin histogram register file path to configurable lane count, bin count and counter width.
- Adds three things the current datapath lacks: a valid/ready input handshake, a pipelined accumulate with in-beat duplicate merging, and saturation.
- Sits beside the vector register file. Consumes LANES pixels per beat and exposes a registered read port for writeback/GET8-style readout.

Parameters:
- LANES, 8, pixels per input beat
- PIX_W, 8, bits per pixel
- BINS, 64, number of histogram bins; power of 2, ≤ 2^PIX_W
- CNT_W, 16, bits per bin counter
- (derived) BIN_W = log2(BINS); SHIFT = PIX_W − BIN_W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  start pulse: zero all bins, then accumulate
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts a beat this cycle
- in_data  in  LANES*PIX_W  packed pixels; lane i = bits [i*PIX_W +: PIX_W]
- in_mask  in  LANES  per-lane enable; 0 = lane ignored
- in_last  in  1  marks the final beat of a frame
- busy  out  1  state is CLEAR, ACCUM or DRAIN
- done  out  1  high while state is DONE
- sat_flag  out  1  sticky: some bin saturated in this frame
- rd_en  in  1  read request
- rd_bin  in  BIN_W  bin to read
- rd_valid  out  1  rd_data valid
- rd_data  out  CNT_W  bin count

Behaviour:
- Reset (reset=0, async): state=IDLE; all counters=0; in_ready=0, busy=0, done=0, sat_flag=0, rd_valid=0, rd_data=0; pipeline valids cleared. Reset mid-frame discards in-flight beats.
- States:
  - IDLE: on clear → CLEAR; sat_flag←0; clr_idx←0.
  - CLEAR: zeroes bin clr_idx each cycle; after clr_idx=BINS−1 → ACCUM. Lasts exactly BINS cycles.
  - ACCUM: in_ready=1; a beat is accepted when in_valid&in_ready. An accepted beat with in_last=1 → DRAIN, and in_ready drops the next cycle.
  - DRAIN: 2 cycles, until the pipeline is empty → DONE.
  - DONE: on clear → CLEAR (new frame); otherwise hold.
- clear outside IDLE/DONE is ignored.
- Pipeline:
  - S1 register: bin_i = pixel_i >> SHIFT, plus mask.
  - S2: inc[b] = count of masked lanes with bin_i==b, range 0..LANES, merging duplicates within the beat; cnt[b] ← sat(cnt[b]+inc[b]).
  - A beat accepted in cycle t is visible on the read port for rd_en issued at cycle t+2 or later.
- Arithmetic: sum computed at CNT_W+1 bits. If it exceeds 2^CNT_W−1, clamp to all-ones and set sat_flag. sat_flag stays set until the next clear.
- Back-to-back beats to the same bin need no stall: counters are a flop array and each bin is updated once per cycle with the merged increment.
- in_mask=0 beat: accepted, no counter changes. in_last with mask=0 still ends the frame.
- Read port:
  - Allowed only in IDLE/DONE. rd_en at cycle t → rd_valid=1 and rd_data=cnt[rd_bin] at t+1.
  - rd_en in other states → rd_valid=0 at t+1; rd_data holds its last value.
  - rd_valid is a one-cycle pulse per request.
- Simultaneous clear and rd_en in DONE: read returns the pre-clear value; CLEAR starts the same edge.

Decomposition:
- Package hist_pkg: state enum (IDLE, CLEAR, ACCUM, DRAIN, DONE) and a saturating-add function parametrised on CNT_W.
- Sub-module hist_merge: combinational LANES→BINS increment-vector generator (popcount per bin), used inside the S2 stage.

Test Plan:
- Reset then clear → busy=1 for exactly 64 CLEAR cycles, then in_ready=1. Read any bin after done → 0.
- One beat of pixels 0,4,8,…,28 (bins 0..7), mask=FF, in_last → done 3 cycles after acceptance. rd bins 0..7 → 1 each; rd bin 8 → 0.
- One beat with all 8 pixels=0xFF, mask=0x0F → bin 63 = 4, all other bins 0.
- CNT_W=4: two beats of 8×0x00 → bin 0 = 15 (clamped from 16), sat_flag=1. A following clear drops sat_flag to 0.
- in_valid toggled 1/0 across 5 beats with identical pixels 0x40 → bin 16 = 40. in_ready deasserts the cycle after the in_last acceptance.
- Reset asserted mid-ACCUM → outputs go to reset values immediately. rd of bin 16 after reset release returns 0 with rd_valid=1.
